// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and encodings for the multi-cycle controller and its ALU
// decoder: FSM state enum, RV32I opcode/funct constants, ALU operation
// codes, immediate format selects and datapath mux select encodings.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // One state per controller step; S_JAL is only reachable when JAL_EN is defined
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_I,
    S_EXEC_R,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  // Major opcodes of the supported subset
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // funct3 / funct7 values we accept
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_ADD  = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  // ALU operations; remaining codes are reserved
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001
  } alu_ctrl_t;

  // Immediate generator format select
  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_src_t;

  // Datapath mux encodings
  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;
  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_OLDPC  = 2'd1;
  localparam logic [1:0] SRCA_RS1    = 2'd2;
  localparam logic [1:0] SRCB_RS2    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_FOUR   = 2'd2;
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational decode of opcode/funct3/funct7 into the ALU operation used
// by the R-type execute step and a flag telling the FSM whether the
// instruction belongs to the supported subset.
// Configuration macro: JAL_EN (when defined, opcode 0x6F is legal).
// Ports:
//   i_opcode   [6:0]  IR[6:0]
//   i_funct3   [2:0]  IR[14:12]
//   i_funct7   [6:0]  IR[31:25]
//   o_alu_ctrl [2:0]  ALU operation (000 add, 001 sub)
//   o_legal           1 = supported instruction
// ---------------------------------------------------------------------------
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [2:0] o_alu_ctrl,
  output logic       o_legal
);

  // Everything outside the listed encodings is illegal and sends the FSM to TRAP
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_legal    = 1'b0;
    case (i_opcode)
      OP_IMM: begin
        o_legal = (i_funct3 == F3_ADD);
      end
      OP_REG: begin
        if (i_funct3 == F3_ADD && i_funct7 == F7_ADD) begin
          o_legal = 1'b1;
        end else if (i_funct3 == F3_ADD && i_funct7 == F7_SUB) begin
          o_legal    = 1'b1;
          o_alu_ctrl = ALU_SUB;
        end
      end
      OP_LOAD, OP_STORE: begin
        o_legal = (i_funct3 == F3_WORD);
      end
      OP_BRANCH: begin
        o_legal    = (i_funct3 == F3_BEQ) || (i_funct3 == F3_BNE);
        o_alu_ctrl = ALU_SUB;
      end
`ifdef JAL_EN
      OP_JAL: begin
        o_legal = 1'b1;
      end
`endif
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle controller for the RV32I-subset core (addi, add, sub, lw, sw,
// beq, bne, and jal when JAL_EN is defined). Sequences one shared ALU and one
// unified memory port, driving PC/IR enables, mux selects, ALU op and
// register write-back. A wait counter traps the core if memory never answers.
// Configuration macro: JAL_EN (adds the JAL state; otherwise 0x6F traps).
// Parameter: MEM_TIMEOUT (wait cycles before trap, 0 = wait forever).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_instr    [31:0] IR contents, valid from DECODE onward
//   i_eq              ALU equality flag
//   i_mem_ready       memory completes current request this cycle
//   o_mem_req/o_mem_we/o_addr_src   memory request, store, address select
//   o_pc_write/o_ir_write/o_reg_write  state element enables
//   o_alu_src_a/o_alu_src_b [1:0], o_alu_ctrl [2:0], o_imm_src [1:0]
//   o_result_src [1:0] result mux select
//   o_illegal         sticky trap indication
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_eq,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_addr_src,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [2:0]  o_alu_ctrl,
  output logic [1:0]  o_imm_src,
  output logic [1:0]  o_result_src,
  output logic        o_illegal
);

  localparam int CNT_W = 16;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [2:0] w_dec_alu_ctrl;
  logic       w_legal;
  logic       w_unused_instr_bits;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_addr_src;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_ctrl;
  logic [1:0] w_imm_src;
  logic [1:0] w_result_src;
  logic       w_mem_wait;
  logic       w_timeout;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  // Register and immediate fields belong to the datapath, not the controller
  assign w_unused_instr_bits = ^{i_instr[24:15], i_instr[11:7]};

  alu_decoder u_alu_decoder (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7   (w_funct7),
    .o_alu_ctrl (w_dec_alu_ctrl),
    .o_legal    (w_legal)
  );

  // A request that memory has not yet accepted; MEM_TIMEOUT of these in a row traps
  assign w_mem_wait = w_mem_req && !i_mem_ready;
  assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait &&
                      (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // State register and wait counter; the counter restarts whenever the state moves
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_mem_wait) begin
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  // Next-state logic; memory states hold until mem_ready, timeout overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (i_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_next = S_TRAP;
        end else begin
          case (w_opcode)
            OP_IMM:            w_next = S_EXEC_I;
            OP_REG:            w_next = S_EXEC_R;
            OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
            OP_BRANCH:         w_next = S_BRANCH;
`ifdef JAL_EN
            OP_JAL:            w_next = S_JAL;
`endif
            default:           w_next = S_TRAP;
          endcase
        end
      end
      S_EXEC_I:   w_next = S_WB_ALU;
      S_EXEC_R:   w_next = S_WB_ALU;
      S_WB_ALU:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = (w_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (i_mem_ready) w_next = S_WB_MEM;
      S_WB_MEM:   w_next = S_FETCH;
      S_MEM_WR:   if (i_mem_ready) w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_WB_ALU;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next = S_TRAP;
    end
  end

  // Output decode: Moore per state, except the FETCH enables (gated by
  // mem_ready) and the branch PC write (gated by the equality flag)
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_src   = ADDR_PC;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_RS2;
    w_alu_ctrl   = ALU_ADD;
    w_imm_src    = IMM_I;
    w_result_src = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_pc_write   = i_mem_ready;
        w_ir_write   = i_mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        w_imm_src   = IMM_B;
`ifdef JAL_EN
        // The jump target lands in ALUOut from this step, so it needs the J immediate
        if (w_opcode == OP_JAL) w_imm_src = IMM_J;
`endif
      end
      S_EXEC_I: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
      end
      S_EXEC_R: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_ctrl  = w_dec_alu_ctrl;
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
        w_imm_src   = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin
        w_mem_req  = 1'b1;
        w_addr_src = ADDR_ALUOUT;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_result_src = RES_MEM;
      end
      S_MEM_WR: begin
        w_mem_req  = 1'b1;
        w_mem_we   = 1'b1;
        w_addr_src = ADDR_ALUOUT;
      end
      S_BRANCH: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_ctrl  = ALU_SUB;
        w_pc_write  = (w_funct3 == F3_BEQ) ? i_eq : !i_eq;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_FOUR;
        w_pc_write  = 1'b1;
      end
      default: begin
        w_mem_req = 1'b0;
      end
    endcase
  end

  // Reset forces every output low immediately so no write can complete mid-instruction
  assign o_mem_req    = w_mem_req   & ~i_rst;
  assign o_mem_we     = w_mem_we    & ~i_rst;
  assign o_addr_src   = w_addr_src  & ~i_rst;
  assign o_pc_write   = w_pc_write  & ~i_rst;
  assign o_ir_write   = w_ir_write  & ~i_rst;
  assign o_reg_write  = w_reg_write & ~i_rst;
  assign o_alu_src_a  = i_rst ? 2'd0 : w_alu_src_a;
  assign o_alu_src_b  = i_rst ? 2'd0 : w_alu_src_b;
  assign o_alu_ctrl   = i_rst ? 3'd0 : w_alu_ctrl;
  assign o_imm_src    = i_rst ? 2'd0 : w_imm_src;
  assign o_result_src = i_rst ? 2'd0 : w_result_src;
  assign o_illegal    = (r_state == S_TRAP) & ~i_rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed scenarios followed by random instruction streams for the
// multi-cycle controller. Expected outputs come from a per-instruction step
// list built from the instruction's class and its memory stall counts.
// A second instance with MEM_TIMEOUT=0 shares all inputs.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       addrSrc;
    logic       pcWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluCtrl;
    logic [1:0] immSrc;
    logic [1:0] resultSrc;
    logic       illegal;
  } outs_t;

  localparam int K_ADDI = 0, K_ADD = 1, K_SUB = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_JAL = 7, K_BAD = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        eq;
  logic        memReady;

  logic memReq, memWe, addrSrc, pcWrite, irWrite, regWrite, illegal;
  logic [1:0] aluSrcA, aluSrcB, immSrc, resultSrc;
  logic [2:0] aluCtrl;

  logic zMemReq, zMemWe, zAddrSrc, zPcWrite, zIrWrite, zRegWrite, zIllegal;
  logic [1:0] zAluSrcA, zAluSrcB, zImmSrc, zResultSrc;
  logic [2:0] zAluCtrl;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clock = ~clock;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .i_clk(clock), .i_rst(reset), .i_instr(instr), .i_eq(eq), .i_mem_ready(memReady),
    .o_mem_req(memReq), .o_mem_we(memWe), .o_addr_src(addrSrc), .o_pc_write(pcWrite),
    .o_ir_write(irWrite), .o_reg_write(regWrite), .o_alu_src_a(aluSrcA),
    .o_alu_src_b(aluSrcB), .o_alu_ctrl(aluCtrl), .o_imm_src(immSrc),
    .o_result_src(resultSrc), .o_illegal(illegal)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(0)) dutNoTimeout (
    .i_clk(clock), .i_rst(reset), .i_instr(instr), .i_eq(eq), .i_mem_ready(memReady),
    .o_mem_req(zMemReq), .o_mem_we(zMemWe), .o_addr_src(zAddrSrc), .o_pc_write(zPcWrite),
    .o_ir_write(zIrWrite), .o_reg_write(zRegWrite), .o_alu_src_a(zAluSrcA),
    .o_alu_src_b(zAluSrcB), .o_alu_ctrl(zAluCtrl), .o_imm_src(zImmSrc),
    .o_result_src(zResultSrc), .o_illegal(zIllegal)
  );

  // Expected output vectors for each controller step
  function automatic outs_t oZero();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t oFetch(input logic ready);
    outs_t o = '0;
    o.memReq = 1'b1; o.aluSrcB = 2'd2;
    o.pcWrite = ready; o.irWrite = ready;
    o.resultSrc = ready ? 2'd2 : 2'd0;
    return o;
  endfunction

  function automatic outs_t oDecode();
    outs_t o = '0;
    o.aluSrcA = 2'd1; o.aluSrcB = 2'd1; o.immSrc = 2'd2;
    return o;
  endfunction

  function automatic outs_t oExecI();
    outs_t o = '0;
    o.aluSrcA = 2'd2; o.aluSrcB = 2'd1; o.immSrc = 2'd0;
    return o;
  endfunction

  function automatic outs_t oExecR(input logic isSub);
    outs_t o = '0;
    o.aluSrcA = 2'd2; o.aluSrcB = 2'd0; o.aluCtrl = isSub ? 3'b001 : 3'b000;
    return o;
  endfunction

  function automatic outs_t oWbAlu();
    outs_t o = '0;
    o.regWrite = 1'b1; o.resultSrc = 2'd0;
    return o;
  endfunction

  function automatic outs_t oMemAddr(input logic isStore);
    outs_t o = '0;
    o.aluSrcA = 2'd2; o.aluSrcB = 2'd1; o.immSrc = isStore ? 2'd1 : 2'd0;
    return o;
  endfunction

  function automatic outs_t oMemRd();
    outs_t o = '0;
    o.memReq = 1'b1; o.addrSrc = 1'b1;
    return o;
  endfunction

  function automatic outs_t oWbMem();
    outs_t o = '0;
    o.regWrite = 1'b1; o.resultSrc = 2'd1;
    return o;
  endfunction

  function automatic outs_t oMemWr();
    outs_t o = '0;
    o.memReq = 1'b1; o.memWe = 1'b1; o.addrSrc = 1'b1;
    return o;
  endfunction

  function automatic outs_t oBranch(input logic taken);
    outs_t o = '0;
    o.aluSrcA = 2'd2; o.aluSrcB = 2'd0; o.aluCtrl = 3'b001; o.pcWrite = taken;
    return o;
  endfunction

  function automatic outs_t oJal();
    outs_t o = '0;
    o.aluSrcA = 2'd1; o.aluSrcB = 2'd2; o.pcWrite = 1'b1;
    return o;
  endfunction

  function automatic outs_t oTrap();
    outs_t o = '0;
    o.illegal = 1'b1;
    return o;
  endfunction

  function automatic outs_t maskAll();
    outs_t m = '1;
    return m;
  endfunction

  // result_src is only defined in FETCH on the completing cycle
  function automatic outs_t maskNoRes();
    outs_t m = '1;
    m.resultSrc = 2'd0;
    return m;
  endfunction

  // Instruction class straight from the supported-encoding list
  function automatic int classify(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
    if (op == 7'h03 && f3 == 3'd2) return K_LW;
    if (op == 7'h23 && f3 == 3'd2) return K_SW;
    if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
    if (op == 7'h63 && f3 == 3'd1) return K_BNE;
`ifdef JAL_EN
    if (op == 7'h6F) return K_JAL;
`endif
    return K_BAD;
  endfunction

  // Random instruction of a requested class with random register/immediate fields
  function automatic logic [31:0] mkInstr(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      K_ADDI: begin r[6:0] = 7'h13; r[14:12] = 3'd0; end
      K_ADD:  begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'h00; end
      K_SUB:  begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'h20; end
      K_LW:   begin r[6:0] = 7'h03; r[14:12] = 3'd2; end
      K_SW:   begin r[6:0] = 7'h23; r[14:12] = 3'd2; end
      K_BEQ:  begin r[6:0] = 7'h63; r[14:12] = 3'd0; end
      K_BNE:  begin r[6:0] = 7'h63; r[14:12] = 3'd1; end
      K_JAL:  begin r[6:0] = 7'h6F; end
      default: begin
        case ($urandom_range(0, 4))
          0: r[6:0] = 7'h7F;
          1: begin r[6:0] = 7'h13; r[14:12] = 3'd1; end
          2: begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'h01; end
          3: begin r[6:0] = 7'h03; r[14:12] = 3'd0; end
          default: begin r[6:0] = 7'h63; r[14:12] = 3'd4; end
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic outs_t observed(input bit second);
    outs_t o;
    if (second)
      o = {zMemReq, zMemWe, zAddrSrc, zPcWrite, zIrWrite, zRegWrite,
           zAluSrcA, zAluSrcB, zAluCtrl, zImmSrc, zResultSrc, zIllegal};
    else
      o = {memReq, memWe, addrSrc, pcWrite, irWrite, regWrite,
           aluSrcA, aluSrcB, aluCtrl, immSrc, resultSrc, illegal};
    return o;
  endfunction

  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input outs_t exp, input outs_t mask, input string tag, input bit second);
    outs_t obs;
    outs_t want;
    obs  = observed(second) & mask;
    want = exp & mask;
    testsRun++;
    assert (obs === want) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check at the falling edge
  task automatic applyStimulus(input logic mr, input logic eqv, input outs_t exp,
                               input outs_t mask, input string tag);
    memReady = mr;
    eq = eqv;
    @(negedge clock);
    checkOutput(exp, mask, tag, 1'b0);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    memReady = dc();
    @(negedge clock);
    checkOutput(oZero(), maskAll(), "reset_outputs", 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Full instruction: nf fetch stalls, nm memory stalls, eqv held as the ALU flag
  task automatic runInstr(input logic [31:0] ins, input logic eqv, input int nf, input int nm);
    int kind;
    outs_t decMask;
    kind = classify(ins);
    instr = ins;
    for (int i = 0; i < nf; i++) applyStimulus(1'b0, eqv, oFetch(1'b0), maskNoRes(), "fetch_wait");
    applyStimulus(1'b1, eqv, oFetch(1'b1), maskAll(), "fetch_done");
    decMask = maskAll();
    if (kind == K_JAL) decMask.immSrc = 2'd0;
    applyStimulus(dc(), eqv, oDecode(), decMask, "decode");
    case (kind)
      K_ADDI: begin
        applyStimulus(dc(), eqv, oExecI(), maskAll(), "exec_i");
        applyStimulus(dc(), eqv, oWbAlu(), maskAll(), "wb_alu");
      end
      K_ADD, K_SUB: begin
        applyStimulus(dc(), eqv, oExecR(kind == K_SUB), maskAll(), "exec_r");
        applyStimulus(dc(), eqv, oWbAlu(), maskAll(), "wb_alu");
      end
      K_LW: begin
        applyStimulus(dc(), eqv, oMemAddr(1'b0), maskAll(), "mem_addr_lw");
        for (int i = 0; i < nm; i++) applyStimulus(1'b0, eqv, oMemRd(), maskAll(), "mem_rd_wait");
        applyStimulus(1'b1, eqv, oMemRd(), maskAll(), "mem_rd_done");
        applyStimulus(dc(), eqv, oWbMem(), maskAll(), "wb_mem");
      end
      K_SW: begin
        applyStimulus(dc(), eqv, oMemAddr(1'b1), maskAll(), "mem_addr_sw");
        for (int i = 0; i < nm; i++) applyStimulus(1'b0, eqv, oMemWr(), maskAll(), "mem_wr_wait");
        applyStimulus(1'b1, eqv, oMemWr(), maskAll(), "mem_wr_done");
      end
      K_BEQ: applyStimulus(dc(), eqv, oBranch(eqv), maskAll(), "branch_beq");
      K_BNE: applyStimulus(dc(), eqv, oBranch(!eqv), maskAll(), "branch_bne");
      K_JAL: begin
        applyStimulus(dc(), eqv, oJal(), maskAll(), "jal");
        applyStimulus(dc(), eqv, oWbAlu(), maskAll(), "jal_wb_alu");
      end
      default: begin
        for (int i = 0; i < 3; i++) applyStimulus(dc(), eqv, oTrap(), maskAll(), "trap");
        doReset();
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    instr = 32'h0;
    eq = 1'b0;
    memReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput(oZero(), maskAll(), "reset_state", 1'b0);
    checkOutput(oZero(), maskAll(), "reset_state_nt", 1'b1);
    reset = 1'b0;

    // addi x1,x0,5 with memory always ready
    runInstr(32'h00500093, 1'b0, 0, 0);

    // lw with three stall cycles in MEM_RD
    runInstr(32'h0080A103, 1'b0, 0, 3);

    // Branch decisions
    runInstr(32'h00209463, 1'b0, 0, 0);
    runInstr(32'h00209463, 1'b1, 0, 0);
    runInstr(32'h00208463, 1'b1, 0, 0);
    runInstr(32'h00208463, 1'b0, 1, 0);

    // sub and sw with stalls
    runInstr(32'h402081B3, 1'b0, 2, 0);
    runInstr(32'h0020A423, 1'b0, 1, 2);

    // Unsupported opcode: trap held 20 cycles, then reset
    instr = 32'h0000007F;
    applyStimulus(1'b1, 1'b0, oFetch(1'b1), maskAll(), "fetch_bad");
    applyStimulus(dc(), 1'b0, oDecode(), maskAll(), "decode_bad");
    for (int i = 0; i < 20; i++) applyStimulus(dc(), dc(), oTrap(), maskAll(), "trap_hold");
    doReset();
    runInstr(32'h00500093, 1'b0, 0, 0);

    // Memory never answers in FETCH: 16 wait cycles, then trap; no-timeout copy keeps waiting
    for (int i = 0; i < 16; i++) begin
      memReady = 1'b0;
      @(negedge clock);
      checkOutput(oFetch(1'b0), maskNoRes(), "timeout_wait", 1'b0);
      checkOutput(oFetch(1'b0), maskNoRes(), "no_timeout_wait", 1'b1);
      @(posedge clock);
      #1;
    end
    for (int i = 0; i < 24; i++) begin
      memReady = 1'b0;
      @(negedge clock);
      checkOutput(oTrap(), maskAll(), "timeout_trap", 1'b0);
      checkOutput(oFetch(1'b0), maskNoRes(), "no_timeout_still_waiting", 1'b1);
      @(posedge clock);
      #1;
    end
    doReset();

    // Reset while a store is waiting on memory
    instr = 32'h0020A423;
    applyStimulus(1'b1, 1'b0, oFetch(1'b1), maskAll(), "fetch_sw");
    applyStimulus(dc(), 1'b0, oDecode(), maskAll(), "decode_sw");
    applyStimulus(dc(), 1'b0, oMemAddr(1'b1), maskAll(), "mem_addr_sw");
    applyStimulus(1'b0, 1'b0, oMemWr(), maskAll(), "mem_wr_wait");
    reset = 1'b1;
    memReady = 1'b0;
    @(negedge clock);
    checkOutput(oZero(), maskAll(), "rst_in_mem_wr", 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput(oZero(), maskAll(), "rst_next_cycle", 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    runInstr(32'h00500093, 1'b0, 0, 0);

`ifdef JAL_EN
    runInstr(32'h008000EF, 1'b0, 0, 0);
`endif

    // Random instruction stream, including illegal encodings and 0x6F
    for (int n = 0; n < 60; n++) begin
      runInstr(mkInstr($urandom_range(0, 8)), dc(), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
